// File: rtl/fp_accum_ctrl.sv
// Stream accumulator that sequences an external combinational/pipelined FP32 adder.
// Optional special-value tracking (NaN/Inf sticky flags) when FP_ACC_SPECIALS_EN is defined.
module fp_accum_ctrl #(
  parameter int unsigned ADD_LAT = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned LAT_W = $clog2(ADD_LAT + 2);
`ifdef FP_ACC_SPECIALS_EN
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;
  localparam logic [31:0] NINF = 32'hFF80_0000;
`endif

  typedef enum logic [1:0] {ACCUM, BUSY, OUT} state_t;

  state_t             state, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        op_q, op_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [LAT_W-1:0]   lat, lat_d;
  logic               in_ready_d, out_valid_d;
  logic [31:0]        out_data_d;
`ifdef FP_ACC_SPECIALS_EN
  logic               nan_q, nan_d, pinf_q, pinf_d, ninf_q, ninf_d;
`endif

  assign add_a     = acc_q;
  assign add_b     = op_q;
  assign out_count = cnt;

  // State and datapath registers; handshake flags and result are registered from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc_q     <= '0;
      op_q      <= '0;
      last_q    <= 1'b0;
      cnt       <= '0;
      lat       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef FP_ACC_SPECIALS_EN
      nan_q     <= 1'b0;
      pinf_q    <= 1'b0;
      ninf_q    <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      last_q    <= last_d;
      cnt       <= cnt_d;
      lat       <= lat_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
`ifdef FP_ACC_SPECIALS_EN
      nan_q     <= nan_d;
      pinf_q    <= pinf_d;
      ninf_q    <= ninf_d;
`endif
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state;
    acc_d   = acc_q;
    op_d    = op_q;
    last_d  = last_q;
    cnt_d   = cnt;
    lat_d   = lat;
`ifdef FP_ACC_SPECIALS_EN
    nan_d   = nan_q;
    pinf_d  = pinf_q;
    ninf_d  = ninf_q;
`endif

    case (state)
      ACCUM: begin
        if (in_valid && in_ready) begin
          op_d    = in_data;
          last_d  = in_last;
          lat_d   = '0;
          state_d = BUSY;
          if (cnt != {CNT_W{1'b1}}) cnt_d = cnt + CNT_W'(1);
`ifdef FP_ACC_SPECIALS_EN
          // Specials bypass the adder: record them and add +0 instead.
          if (in_data[30:23] == 8'hFF) begin
            op_d = '0;
            if (in_data[22:0] != 23'd0) nan_d  = 1'b1;
            else if (in_data[31])       ninf_d = 1'b1;
            else                        pinf_d = 1'b1;
          end
`endif
        end
      end
      BUSY: begin
        if (lat == LAT_W'(ADD_LAT)) begin
          acc_d   = add_s;
`ifdef FP_ACC_SPECIALS_EN
          if (add_s[30:23] == 8'hFF) begin
            acc_d = acc_q;
            if (add_s[31]) ninf_d = 1'b1;
            else           pinf_d = 1'b1;
          end
`endif
          state_d = last_q ? OUT : ACCUM;
        end else begin
          lat_d = lat + LAT_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
`ifdef FP_ACC_SPECIALS_EN
          nan_d   = 1'b0;
          pinf_d  = 1'b0;
          ninf_d  = 1'b0;
`endif
        end
      end
      default: state_d = ACCUM;
    endcase

    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == OUT);

`ifdef FP_ACC_SPECIALS_EN
    if (nan_d || (pinf_d && ninf_d)) out_data_d = QNAN;
    else if (pinf_d)                 out_data_d = PINF;
    else if (ninf_d)                 out_data_d = NINF;
    else                             out_data_d = acc_d;
`else
    out_data_d = acc_d;
`endif
  end

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Scoreboard bench for fp_accum_ctrl: three instances (ADD_LAT=0, ADD_LAT=2, CNT_W=2) with a real-number adder model.
module tb_fp_accum_ctrl;

  localparam int unsigned N = 3;

  logic                  clk;
  logic [N-1:0]          rst, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [N-1:0][31:0]    in_data, add_a, add_b, add_s, out_data;
  logic [N-1:0][15:0]    out_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_sum [N];
  logic [15:0] m_cnt [N];
`ifdef FP_ACC_SPECIALS_EN
  logic m_nan [N], m_pinf [N], m_ninf [N];
`endif

  // Single -> double conversion (subnormals flushed to zero).
  function automatic real to_real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'hFF)
      d = (x[22:0] != 23'd0) ? 64'h7FF8_0000_0000_0000 : {x[31], 11'h7FF, 52'd0};
    else if (x[30:23] == 8'h00)
      d = {x[31], 63'd0};
    else
      d = {x[31], 11'({3'd0, x[30:23]}) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] to_bits(input real r);
    logic [63:0] b;
    int ee;
    b = $realtobits(r);
    if (b[62:52] == 11'h7FF)
      return (b[51:0] != 52'd0) ? 32'h7FC0_0000 : {b[63], 8'hFF, 23'd0};
    ee = int'(b[62:52]) - 896;
    if (ee >= 255) return {b[63], 8'hFF, 23'd0};
    if (ee <= 0)   return {b[63], 31'd0};
    return {b[63], 8'(ee), b[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return to_bits(to_real(a) + to_real(b));
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned LAT = (g == 1) ? 2 : 0;
    localparam int unsigned CW  = (g == 2) ? 2 : 16;
    logic [CW-1:0] cnt_raw;

    fp_accum_ctrl #(.ADD_LAT(LAT), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_last   (in_last[g]),
      .add_a     (add_a[g]),
      .add_b     (add_b[g]),
      .add_s     (add_s[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_count (cnt_raw)
    );
    assign out_count[g] = 16'(cnt_raw);

    if (LAT == 0) begin : g_comb
      assign add_s[g] = fp_add(add_a[g], add_b[g]);
    end else begin : g_pipe
      logic [31:0] s1, s2;
      always @(posedge clk) begin
        s1 <= fp_add(add_a[g], add_b[g]);
        s2 <= s1;
      end
      assign add_s[g] = s2;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_sum[i] = '0;
    m_cnt[i] = '0;
`ifdef FP_ACC_SPECIALS_EN
    m_nan[i] = 1'b0; m_pinf[i] = 1'b0; m_ninf[i] = 1'b0;
`endif
  endtask

  task automatic model_accept(input int i, input logic [31:0] d, input logic last);
    logic [31:0] res, s, op;
    exp_t e;
    op = d;
`ifdef FP_ACC_SPECIALS_EN
    if (d[30:23] == 8'hFF) begin
      op = '0;
      if (d[22:0] != 23'd0) m_nan[i] = 1'b1;
      else if (d[31])       m_ninf[i] = 1'b1;
      else                  m_pinf[i] = 1'b1;
    end
    s = fp_add(m_sum[i], op);
    if (s[30:23] == 8'hFF) begin
      if (s[31]) m_ninf[i] = 1'b1;
      else       m_pinf[i] = 1'b1;
    end else begin
      m_sum[i] = s;
    end
    if (m_nan[i] || (m_pinf[i] && m_ninf[i])) res = 32'h7FC0_0000;
    else if (m_pinf[i])                       res = 32'h7F80_0000;
    else if (m_ninf[i])                       res = 32'hFF80_0000;
    else                                      res = m_sum[i];
`else
    s = fp_add(m_sum[i], op);
    m_sum[i] = s;
    res = s;
`endif
    if (m_cnt[i] != ((i == 2) ? 16'd3 : 16'hFFFF)) m_cnt[i] = m_cnt[i] + 16'd1;
    if (last) begin
      e.inst = i; e.data = res; e.cnt = m_cnt[i];
      sb.push_back(e);
      model_reset(i);
    end
  endtask

  // Drive one word, wait (bounded) for acceptance; returns 1ns after the accepting edge.
  task automatic send_word(input int i, input logic [31:0] d, input logic last);
    int n;
    in_valid[i] = 1'b1; in_data[i] = d; in_last[i] = last;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready[i] && n < 100);
    if (!in_ready[i]) check("accept_timeout", 64'd0, 64'd1);
    else              model_accept(i, d, last);
    @(posedge clk); #1;
    in_valid[i] = 1'b0; in_last[i] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); #1; n++; end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: compare on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (!rst[i] && out_valid[i] && out_ready[i]) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(i), 64'hFFFF);
        end else begin
          e = sb.pop_front();
          check("out_inst",  64'(i), 64'(e.inst));
          check("out_data",  64'(out_data[i]), 64'(e.data));
          check("out_count", 64'(out_count[i]), 64'(e.cnt));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] acc_ref, pend;
    int n;
    rst = '1; in_valid = '0; in_last = '0; in_data = '0; out_ready = '1;
    repeat (2) @(posedge clk);
    #1 rst = '0;
    for (int i = 0; i < N; i++) model_reset(i);

    // Reset values
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("rst_in_ready",  64'(in_ready[i]),  64'd1);
      check("rst_out_valid", 64'(out_valid[i]), 64'd0);
      check("rst_out_data",  64'(out_data[i]),  64'd0);
      check("rst_out_count", 64'(out_count[i]), 64'd0);
      check("rst_add_a",     64'(add_a[i]),     64'd0);
      check("rst_add_b",     64'(add_b[i]),     64'd0);
    end
    @(posedge clk); #1;

    // T1: 1 + 2 + 3
    send_word(0, 32'h3F80_0000, 1'b0);
    send_word(0, 32'h4000_0000, 1'b0);
    send_word(0, 32'h4040_0000, 1'b1);
    wait_drain();

    // T2: single word, out_valid two edges after accept
    send_word(0, 32'hC049_0FDB, 1'b1);
    @(negedge clk);
    check("t2_valid_early", 64'(out_valid[0]), 64'd0);
    check("t2_in_ready",    64'(in_ready[0]),  64'd0);
    @(negedge clk);
    check("t2_valid_on",    64'(out_valid[0]), 64'd1);
    wait_drain();

    // T3: back-pressure in OUT
    out_ready[0] = 1'b0;
    send_word(0, 32'h4040_0000, 1'b1);
    n = 0;
    while (!out_valid[0] && n < 20) begin @(negedge clk); n++; end
    check("t3_reach_out", 64'(out_valid[0]), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_valid", 64'(out_valid[0]), 64'd1);
      check("t3_hold_data",  64'(out_data[0]),  64'h4040_0000);
      check("t3_hold_count", 64'(out_count[0]), 64'd1);
      check("t3_in_ready",   64'(in_ready[0]),  64'd0);
    end
    @(posedge clk); #1 out_ready[0] = 1'b1;
    wait_drain();
    send_word(0, 32'h3F80_0000, 1'b1);
    wait_drain();

    // T4: ADD_LAT=2, in_valid held high
    in_valid[1] = 1'b1; in_data[1] = 32'h3F80_0000; in_last[1] = 1'b0;
    acc_ref = '0; pend = '0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("t4_in_ready", 64'(in_ready[1]), 64'((k % 4) == 0));
      check("t4_add_a",    64'(add_a[1]),    64'(acc_ref));
      if ((k % 4) != 0) check("t4_add_b", 64'(add_b[1]), 64'h3F80_0000);
      if ((k % 4) == 0) begin
        pend = fp_add(acc_ref, 32'h3F80_0000);
        if (k == 8) in_last[1] = 1'b1;
        model_accept(1, 32'h3F80_0000, k == 8);
      end
      if ((k % 4) == 3) acc_ref = pend;
    end
    @(posedge clk); #1;
    in_valid[1] = 1'b0; in_last[1] = 1'b0;
    wait_drain();

    // T5: reset in the middle of BUSY
    send_word(1, 32'h3F80_0000, 1'b0);
    rst[1] = 1'b1;
    @(posedge clk); #1 rst[1] = 1'b0;
    model_reset(1);
    @(negedge clk);
    check("t5_in_ready",  64'(in_ready[1]),  64'd1);
    check("t5_out_valid", 64'(out_valid[1]), 64'd0);
    check("t5_count",     64'(out_count[1]), 64'd0);
    check("t5_add_a",     64'(add_a[1]),     64'd0);
    @(posedge clk); #1;
    send_word(1, 32'h3F80_0000, 1'b0);
    send_word(1, 32'h3F80_0000, 1'b1);
    wait_drain();

    // T6: 1 + Inf + -Inf
    send_word(0, 32'h3F80_0000, 1'b0);
    send_word(0, 32'h7F80_0000, 1'b0);
    send_word(0, 32'hFF80_0000, 1'b1);
    wait_drain();

    // Counter saturation on the 2-bit instance: five words, count stays at 3
    for (int k = 0; k < 5; k++) send_word(2, 32'h3F80_0000, k == 4);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
